// File: rtl/meter_pkg.sv
// Shared segment constants, hex-to-segment lookup and converter state type for meter_display_ctrl.
package meter_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'b1111111;
    localparam seg_t SEG_ZERO  = 7'b1000000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONV,
        ST_LOAD
    } conv_state_t;

    // Active-low segments, bit order gfedcba.
    function automatic seg_t hex_to_seg(input logic [3:0] nib);
        seg_t seg;
        case (nib)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/meter_bcd_conv.sv
// Sequential double-dabble binary-to-BCD converter; used only when METER_BCD_EN is defined.
module meter_bcd_conv
    import meter_pkg::*;
#(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned N_DIGITS = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [DATA_W-1:0]       bin,
    output logic                    load,
    output logic [4*N_DIGITS-1:0]   digits,
    output logic                    overflow
);

    localparam int unsigned N_BCD = (DATA_W + 2) / 3;
    localparam int unsigned BCD_W = 4 * N_BCD;
    localparam int unsigned EXT_W = 4 * (N_BCD + N_DIGITS);
    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    conv_state_t        state_q, state_d;
    logic [DATA_W-1:0]  bin_q, bin_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic [BCD_W-1:0]   adj;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               pending_q, pending_d;
    logic [EXT_W-1:0]   bcd_ext;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            bin_q     <= '0;
            bcd_q     <= '0;
            cnt_q     <= '0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bin_q     <= bin_d;
            bcd_q     <= bcd_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bin_d     = bin_q;
        bcd_d     = bcd_q;
        cnt_d     = cnt_q;
        pending_d = pending_q;
        load      = 1'b0;
        adj       = bcd_q;
        for (int unsigned k = 0; k < N_BCD; k++) begin
            if (adj[4*k +: 4] >= 4'd5) adj[4*k +: 4] = adj[4*k +: 4] + 4'd3;
        end
        case (state_q)
            ST_IDLE: begin
                // Sampling bin here picks up the newest level even when the start was queued.
                if (start || pending_q) begin
                    bin_d     = bin;
                    bcd_d     = '0;
                    cnt_d     = '0;
                    pending_d = 1'b0;
                    state_d   = ST_CONV;
                end
            end
            ST_CONV: begin
                bcd_d = {adj[BCD_W-2:0], bin_q[DATA_W-1]};
                bin_d = bin_q << 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(DATA_W - 1)) state_d = ST_LOAD;
                if (start) pending_d = 1'b1;
            end
            ST_LOAD: begin
                load    = 1'b1;
                state_d = ST_IDLE;
                if (start) pending_d = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bcd_ext  = EXT_W'(bcd_q);
    assign digits   = bcd_ext[4*N_DIGITS-1:0];
    assign overflow = (bcd_ext[EXT_W-1:4*N_DIGITS] != '0);

endmodule

// File: rtl/meter_display_ctrl.sv
// Windowed peak meter driving N_DIGITS seven-segment digits.
// Define METER_BCD_EN for a decimal display via meter_bcd_conv; default is hex.
module meter_display_ctrl
    import meter_pkg::*;
#(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned N_DIGITS = 8,
    parameter int unsigned WINDOW   = 4096,
    parameter int unsigned BLANK_LZ = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              freeze,
    input  logic              clear_peak,
    output logic [DATA_W-1:0] level_out,
    output logic              update_pulse,
    output logic [6:0]        display [N_DIGITS]
);

    localparam int unsigned CNT_W  = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int unsigned SHOW_W = 4 * N_DIGITS;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WINDOW - 1);
    localparam logic [DATA_W-1:0] MAG_MAX  = {1'b0, {(DATA_W-1){1'b1}}};

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] peak_q, peak_d;
    logic [DATA_W-1:0] level_q, level_d;
    logic              update_pulse_q, update_pulse_d;
    seg_t              display_q [N_DIGITS];
    seg_t              display_d [N_DIGITS];
    seg_t              seg_next  [N_DIGITS];

    logic [DATA_W-1:0] mag;
    logic [DATA_W-1:0] peak_max;
    logic [SHOW_W-1:0] shown;
    logic              load_en;

    always_comb begin
        if (!sample_in[DATA_W-1])      mag = sample_in;
        else if (sample_in == ~MAG_MAX) mag = MAG_MAX;
        else                            mag = ~sample_in + 1'b1;
    end

    assign peak_max = (mag > peak_q) ? mag : peak_q;

    always_comb begin
        cnt_d          = cnt_q;
        peak_d         = peak_q;
        level_d        = level_q;
        update_pulse_d = 1'b0;
        if (clear_peak) begin
            cnt_d          = '0;
            peak_d         = '0;
            level_d        = '0;
            update_pulse_d = 1'b1;
        end else if (sample_valid) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d  = '0;
                peak_d = '0;
                if (!freeze) begin
                    level_d        = peak_max;
                    update_pulse_d = 1'b1;
                end
            end else begin
                cnt_d  = cnt_q + 1'b1;
                peak_d = peak_max;
            end
        end
    end

`ifdef METER_BCD_EN
    logic [SHOW_W-1:0] bcd_digits;
    logic              conv_load;
    logic              conv_ovf;

    meter_bcd_conv #(
        .DATA_W   (DATA_W),
        .N_DIGITS (N_DIGITS)
    ) u_bcd_conv (
        .clk      (clk),
        .rst      (rst),
        .start    (update_pulse_q),
        .bin      (level_q),
        .load     (conv_load),
        .digits   (bcd_digits),
        .overflow (conv_ovf)
    );

    assign shown   = conv_ovf ? {N_DIGITS{4'h9}} : bcd_digits;
    assign load_en = conv_load;
`else
    localparam int unsigned EXT_W = SHOW_W + DATA_W;
    logic [EXT_W-1:0] level_ext;

    // Padding to SHOW_W+DATA_W covers both narrower and wider displays than the level.
    assign level_ext = EXT_W'(level_q);
    assign shown     = level_ext[SHOW_W-1:0];
    assign load_en   = update_pulse_q;
`endif

    for (genvar g = 0; g < N_DIGITS; g++) begin : g_digit
        logic upper_zero;
        assign upper_zero  = ((shown >> (4 * g)) == '0);
        assign seg_next[g] = (BLANK_LZ != 0 && g != 0 && upper_zero)
                           ? SEG_BLANK : hex_to_seg(shown[4*g +: 4]);
    end

    always_comb begin
        for (int unsigned i = 0; i < N_DIGITS; i++) begin
            display_d[i] = load_en ? seg_next[i] : display_q[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q          <= '0;
            peak_q         <= '0;
            level_q        <= '0;
            update_pulse_q <= 1'b0;
            for (int unsigned i = 0; i < N_DIGITS; i++) begin
                display_q[i] <= (i == 0 || BLANK_LZ == 0) ? SEG_ZERO : SEG_BLANK;
            end
        end else begin
            cnt_q          <= cnt_d;
            peak_q         <= peak_d;
            level_q        <= level_d;
            update_pulse_q <= update_pulse_d;
            for (int unsigned i = 0; i < N_DIGITS; i++) begin
                display_q[i] <= display_d[i];
            end
        end
    end

    assign level_out    = level_q;
    assign update_pulse = update_pulse_q;
    assign display      = display_q;

endmodule

// File: tb/tb_meter_display_ctrl.sv
// Directed self-checking bench for meter_display_ctrl (DATA_W=16, N_DIGITS=8, WINDOW=4).
// Display expectations switch to decimal when METER_BCD_EN is defined.
module tb_meter_display_ctrl;

    localparam logic [6:0] S0 = 7'h40, S1 = 7'h79, S2 = 7'h24, S3 = 7'h30, S4 = 7'h19;
    localparam logic [6:0] S5 = 7'h12, S6 = 7'h02, S7 = 7'h78, S9 = 7'h10, SF = 7'h0E;

    logic        clk = 1'b0;
    logic        rst;
    logic        sample_valid;
    logic [15:0] sample_in;
    logic        freeze;
    logic        clear_peak;
    logic [15:0] level_out;
    logic        update_pulse;
    logic [6:0]  display [8];

    int unsigned checks   = 0;
    int unsigned failures = 0;
    int unsigned pulses   = 0;
    int unsigned p0;

    always #5 clk = ~clk;

    always @(negedge clk) if (!rst && update_pulse) pulses++;

    meter_display_ctrl #(
        .DATA_W   (16),
        .N_DIGITS (8),
        .WINDOW   (4),
        .BLANK_LZ (0)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_valid (sample_valid),
        .sample_in    (sample_in),
        .freeze       (freeze),
        .clear_peak   (clear_peak),
        .level_out    (level_out),
        .update_pulse (update_pulse),
        .display      (display)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step();
    endtask

    task automatic send(input logic [15:0] v);
        sample_in    = v;
        sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
    endtask

    task automatic window4(input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] c, input logic [15:0] d);
        send(a);
        send(b);
        send(c);
        send(d);
    endtask

    task automatic check_low4(input string tag, input logic [6:0] d3, input logic [6:0] d2,
                              input logic [6:0] d1, input logic [6:0] d0);
        check({tag, "_lo"}, {4'h0, display[3], display[2], display[1], display[0]},
              {4'h0, d3, d2, d1, d0});
        check({tag, "_hi"}, {4'h0, display[7], display[6], display[5], display[4]},
              {4'h0, S0, S0, S0, S0});
    endtask

    initial begin
        rst          = 1'b1;
        sample_valid = 1'b0;
        sample_in    = '0;
        freeze       = 1'b0;
        clear_peak   = 1'b0;
        steps(2);
        rst = 1'b0;
        steps(3);

        check("reset_level", 32'(level_out), 32'h0);
        check("reset_pulse", 32'(pulses), 32'd0);
        check_low4("reset_disp", S0, S0, S0, S0);

        // Window with gaps, one negative sample
        send(16'h0010); step();
        send(16'hFF00); step();
        send(16'h0123); step();
        p0 = pulses;
        send(16'h0005);
        check("win1_level", 32'(level_out), 32'h0123);
        check("win1_pulse", 32'(update_pulse), 32'h1);
`ifndef METER_BCD_EN
        step();
        check("win1_pulse_drop", 32'(update_pulse), 32'h0);
        check_low4("win1_disp", S0, S1, S2, S3);
`else
        steps(17);
        check("bcd_not_yet", 32'(display[0]), 32'(S0));
        step();
        check("bcd_291", {11'h0, display[2], display[1], display[0]}, {11'h0, S2, S9, S1});
`endif
        check("win1_one_pulse", 32'(pulses - p0), 32'd1);

        // Frozen window: level held, no strobe
        freeze = 1'b1;
        p0 = pulses;
        window4(16'h0400, 16'h0400, 16'h0400, 16'h0400);
        check("frz_level", 32'(level_out), 32'h0123);
        check("frz_pulse", 32'(update_pulse), 32'h0);
        step();
        check("frz_no_pulse", 32'(pulses - p0), 32'd0);
        freeze = 1'b0;
`ifndef METER_BCD_EN
        check_low4("frz_disp", S0, S1, S2, S3);
`endif
        window4(16'h0010, 16'h0020, 16'h0400, 16'h0001);
        check("unfrz_level", 32'(level_out), 32'h0400);
        check("unfrz_pulse", 32'(update_pulse), 32'h1);
`ifndef METER_BCD_EN
        step();
        check_low4("unfrz_disp", S0, S4, S0, S0);
`endif

        // Most-negative saturation
        window4(16'h8000, 16'h8000, 16'h8000, 16'h8000);
        check("sat_level", 32'(level_out), 32'h7FFF);
`ifndef METER_BCD_EN
        step();
        check_low4("sat_disp", S7, SF, SF, SF);
`endif

        // clear_peak beats a coincident sample mid-window
        send(16'h0001);
        send(16'h0002);
        clear_peak   = 1'b1;
        sample_in    = 16'h7000;
        sample_valid = 1'b1;
        step();
        clear_peak   = 1'b0;
        sample_valid = 1'b0;
        check("clr_level", 32'(level_out), 32'h0);
        check("clr_pulse", 32'(update_pulse), 32'h1);
`ifndef METER_BCD_EN
        step();
        check_low4("clr_disp", S0, S0, S0, S0);
`endif
        window4(16'h0011, 16'h0022, 16'h0033, 16'h0004);
        check("postclr_level", 32'(level_out), 32'h0033);

        // Reset mid-window discards the partial peak
        send(16'h0500);
        send(16'h0600);
        rst = 1'b1;
        step();
        check("rst_mid_level", 32'(level_out), 32'h0);
        rst = 1'b0;
        step();
        window4(16'h0001, 16'h0002, 16'h0003, 16'h0004);
        check("postrst_level", 32'(level_out), 32'h0004);
`ifndef METER_BCD_EN
        step();
        check_low4("postrst_disp", S0, S0, S0, S4);
`else
        // Second window closes mid-conversion; newest level converted after the first
        steps(40);
        window4(16'h0100, 16'h0100, 16'h0100, 16'h0100);
        check("bcd_a_level", 32'(level_out), 32'h0100);
        window4(16'h0200, 16'h0200, 16'h0200, 16'h0200);
        check("bcd_b_level", 32'(level_out), 32'h0200);
        steps(14);
        check("bcd_256", {11'h0, display[2], display[1], display[0]}, {11'h0, S2, S5, S6});
        steps(17);
        check("bcd_256_held", {11'h0, display[2], display[1], display[0]}, {11'h0, S2, S5, S6});
        step();
        check("bcd_512", {11'h0, display[2], display[1], display[0]}, {11'h0, S5, S1, S2});
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
